// File: rtl/vproc_vreg_wr_arbiter.sv
// vproc_vreg_wr_arbiter: shares PORT_WR_CNT register file write ports among REQ_CNT writeback requesters.
// Define VPROC_VREG_WR_ARB_RR_EN for round-robin priority; otherwise fixed priority (lowest index wins).
module vproc_vreg_wr_arbiter #(
   parameter int REQ_CNT     = 4,
   parameter int PORT_WR_CNT = 2,
   parameter int PORT_W      = 512,
   parameter int ADDR_W      = 5
) (
   input  logic                            clk_i,
   input  logic                            sync_rst_i,
   input  logic [REQ_CNT-1:0]              req_valid_i,
   output logic [REQ_CNT-1:0]              req_ready_o,
   input  logic [REQ_CNT*ADDR_W-1:0]       req_addr_i,
   input  logic [REQ_CNT*PORT_W-1:0]       req_data_i,
   input  logic [REQ_CNT*PORT_W/8-1:0]     req_be_i,
   output logic [PORT_WR_CNT-1:0]          wr_we_o,
   output logic [PORT_WR_CNT*ADDR_W-1:0]   wr_addr_o,
   output logic [PORT_WR_CNT*PORT_W-1:0]   wr_data_o,
   output logic [PORT_WR_CNT*PORT_W/8-1:0] wr_be_o
);
   localparam int BE_W  = PORT_W / 8;
   localparam int SEL_W = REQ_CNT > 1 ? $clog2(REQ_CNT) : 1;
   logic [ADDR_W-1:0] addr_a [REQ_CNT];
   logic [PORT_W-1:0] data_a [REQ_CNT];
   logic [BE_W-1:0]   be_a   [REQ_CNT];
   logic [REQ_CNT-1:0] grant;
   logic [PORT_WR_CNT-1:0] port_vld;
   logic [SEL_W-1:0] port_sel [PORT_WR_CNT];
   logic [SEL_W-1:0] ptr;
   logic coll;
   int cnt;
   logic              we_q   [PORT_WR_CNT];
   logic [ADDR_W-1:0] addr_q [PORT_WR_CNT];
   logic [PORT_W-1:0] data_q [PORT_WR_CNT];
   logic [BE_W-1:0]   be_q   [PORT_WR_CNT];
   for (genvar k = 0; k < REQ_CNT; k++) begin : g_req
      assign addr_a[k] = req_addr_i[k*ADDR_W +: ADDR_W];
      assign data_a[k] = req_data_i[k*PORT_W +: PORT_W];
      assign be_a[k]   = req_be_i[k*BE_W +: BE_W];
   end
   // One greedy pass in scan order fills the ports in order, skipping address collisions.
   always_comb begin
      grant = '0;
      port_vld = '0;
      coll = 1'b0;
      cnt = 0;
      for (int p = 0; p < PORT_WR_CNT; p++) port_sel[p] = '0;
      for (int i = 0; i < REQ_CNT; i++)
         for (int k = 0; k < REQ_CNT; k++)
            if (k == (int'(ptr) + i) % REQ_CNT) begin
               coll = 1'b0;
               for (int j = 0; j < REQ_CNT; j++)
                  if (grant[j] && addr_a[j] == addr_a[k]) coll = 1'b1;
               if (req_valid_i[k] && !coll && cnt < PORT_WR_CNT) begin
                  grant[k] = 1'b1;
                  for (int p = 0; p < PORT_WR_CNT; p++)
                     if (p == cnt) begin
                        port_vld[p] = 1'b1;
                        port_sel[p] = SEL_W'(k);
                     end
                  cnt = cnt + 1;
               end
            end
   end
   assign req_ready_o = sync_rst_i ? '0 : grant;
`ifdef VPROC_VREG_WR_ARB_RR_EN
   logic [SEL_W-1:0] ptr_q, ptr_d;
   always_comb begin
      ptr_d = ptr_q;
      for (int i = 0; i < REQ_CNT; i++)
         for (int k = 0; k < REQ_CNT; k++)
            if (k == (int'(ptr_q) + i) % REQ_CNT && grant[k]) ptr_d = SEL_W'((k + 1) % REQ_CNT);
   end
   always_ff @(posedge clk_i) ptr_q <= sync_rst_i ? '0 : ptr_d;
   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < PORT_WR_CNT; p++) begin
         if (sync_rst_i) begin
            we_q[p]   <= 1'b0;
            addr_q[p] <= '0;
            data_q[p] <= '0;
            be_q[p]   <= '0;
         end else begin
            we_q[p] <= port_vld[p];
            if (port_vld[p]) begin
               addr_q[p] <= addr_a[port_sel[p]];
               data_q[p] <= data_a[port_sel[p]];
               be_q[p]   <= be_a[port_sel[p]];
            end
         end
      end
   end
   for (genvar p = 0; p < PORT_WR_CNT; p++) begin : g_port
      assign wr_we_o[p]                  = we_q[p];
      assign wr_addr_o[p*ADDR_W +: ADDR_W] = addr_q[p];
      assign wr_data_o[p*PORT_W +: PORT_W] = data_q[p];
      assign wr_be_o[p*BE_W +: BE_W]       = be_q[p];
   end
endmodule

// File: tb/tb_vproc_vreg_wr_arbiter.sv
// tb_vproc_vreg_wr_arbiter: directed scoreboard bench for vproc_vreg_wr_arbiter (REQ_CNT=4, PORT_WR_CNT=2).
module tb_vproc_vreg_wr_arbiter;
   localparam int N = 4, P = 2, W = 512, AW = 5, BW = W / 8;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic [N-1:0] v = '0, rdy;
   logic [AW-1:0] a [N];
   logic [W-1:0] d [N];
   logic [BW-1:0] b [N];
   logic [P-1:0] wr_we;
   logic [P*AW-1:0] wr_addr;
   logic [P*W-1:0] wr_data;
   logic [P*BW-1:0] wr_be;
   vproc_vreg_wr_arbiter #(.REQ_CNT(N), .PORT_WR_CNT(P), .PORT_W(W), .ADDR_W(AW)) dut (
      .clk_i(clk), .sync_rst_i(rst), .req_valid_i(v), .req_ready_o(rdy),
      .req_addr_i({a[3], a[2], a[1], a[0]}), .req_data_i({d[3], d[2], d[1], d[0]}),
      .req_be_i({b[3], b[2], b[1], b[0]}),
      .wr_we_o(wr_we), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_be_o(wr_be)
   );
   typedef struct {
      logic [P-1:0] we;
      logic [AW-1:0] a0, a1;
      logic cd;
      logic [W-1:0] d0;
      logic [BW-1:0] b0;
   } exp_t;
   exp_t q[$];
   exp_t me;
   int nchk = 0, nfail = 0;
   int cnt [N];
   task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask
   task automatic push_d(input logic [P-1:0] we, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic cd, input logic [W-1:0] d0, input logic [BW-1:0] b0);
      exp_t e;
      e.we = we; e.a0 = a0; e.a1 = a1; e.cd = cd; e.d0 = d0; e.b0 = b0;
      q.push_back(e);
   endtask
   task automatic push(input logic [P-1:0] we, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      push_d(we, a0, a1, 1'b0, '0, '0);
   endtask
   task automatic step();
      @(posedge clk);
      #2;
   endtask
   task automatic defaults();
      for (int k = 0; k < N; k++) begin
         a[k] = AW'(k + 1);
         d[k] = {64{8'(8'h11 * (k + 1))}};
         b[k] = '1;
      end
   endtask
   // Monitor: every cycle the write ports are active, the oldest expected write must match.
   always @(posedge clk) begin
      #1;
      if (wr_we != '0) begin
         if (q.size() == 0) chk("unexpected_write", W'(wr_we), '0);
         else begin
            me = q.pop_front();
            chk("wr_we", W'(wr_we), W'(me.we));
            chk("wr_addr0", W'(wr_addr[AW-1:0]), W'(me.a0));
            chk("wr_addr1", W'(wr_addr[2*AW-1:AW]), W'(me.a1));
            if (me.cd) begin
               chk("wr_data0", wr_data[W-1:0], me.d0);
               chk("wr_be0", W'(wr_be[BW-1:0]), W'(me.b0));
            end
         end
      end
   end
   initial begin
      defaults();
      rst = 1'b1;
      v = 4'hF;
      step();
      step();
      chk("rst_ready", W'(rdy), '0);
      chk("rst_we", W'(wr_we), '0);
      rst = 1'b0;
      #1 chk("rel_ready", W'(rdy), W'(4'b0011));
      push(2'b11, 5'd1, 5'd2);
      step();
      v = 4'b1100;
      #1 chk("dist_ready", W'(rdy), W'(4'b1100));
      push(2'b11, 5'd3, 5'd4);
      step();
      v = '0;
      #1 chk("idle_ready", W'(rdy), '0);
      step();
      a[0] = 5'd7; a[1] = 5'd7; a[2] = 5'd9;
      v = 4'b0111;
      #1 chk("coll_ready0", W'(rdy), W'(4'b0101));
      push(2'b11, 5'd7, 5'd9);
      step();
      v = 4'b0010;
      #1 chk("coll_ready1", W'(rdy), W'(4'b0010));
      push(2'b01, 5'd7, 5'd9);
      step();
      v = '0;
      defaults();
      for (int k = 0; k < N; k++) cnt[k] = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         v = 4'hF;
         #1;
         for (int k = 0; k < N; k++) cnt[k] += int'(rdy[k]);
`ifdef VPROC_VREG_WR_ARB_RR_EN
         if (c % 2 == 0) push(2'b11, 5'd3, 5'd4);
         else push(2'b11, 5'd1, 5'd2);
`else
         push(2'b11, 5'd1, 5'd2);
`endif
      end
      step();
      v = '0;
`ifdef VPROC_VREG_WR_ARB_RR_EN
      for (int k = 0; k < N; k++) chk($sformatf("fair_cnt%0d", k), W'(cnt[k]), W'(4));
`else
      for (int k = 0; k < N; k++) chk($sformatf("fixed_cnt%0d", k), W'(cnt[k]), W'(k < 2 ? 8 : 0));
`endif
      step();
      a[3] = 5'd31;
      d[3] = {64{8'hA5}};
      b[3] = {8{8'h0F}};
      v = 4'b1000;
      #1 chk("pass_ready", W'(rdy), W'(4'b1000));
      push_d(2'b01, 5'd31, 5'd2, 1'b1, {64{8'hA5}}, {8{8'h0F}});
      step();
      a[1] = 5'd5;
      b[1] = '0;
      v = 4'b0010;
      #1 chk("be0_ready", W'(rdy), W'(4'b0010));
      push_d(2'b01, 5'd5, 5'd2, 1'b1, {64{8'h22}}, '0);
      step();
      v = '0;
      defaults();
      step();
      v = 4'b0011;
      #1 chk("pre_rst_ready", W'(rdy), W'(4'b0011));
      push(2'b11, 5'd1, 5'd2);
      step();
      v = 4'b1100;
      rst = 1'b1;
      #1 chk("mid_rst_ready", W'(rdy), '0);
      step();
      rst = 1'b0;
      chk("post_rst_we", W'(wr_we), '0);
      chk("post_rst_addr", W'(wr_addr), '0);
      v = 4'hF;
      #1 chk("post_rst_ptr_ready", W'(rdy), W'(4'b0011));
      push(2'b11, 5'd1, 5'd2);
      step();
      v = '0;
      step();
      step();
      chk("queue_empty", W'(q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
